// File: rtl/autotest_sweep_ctrl.sv
// Sweep sequencer for the SD host under test: runs every configuration of block
// count, SCLK speed and CMD18 mode, times each run and streams an 8-byte result record.
module autotest_sweep_ctrl #(
   parameter logic [31:0] N_BLOCKS_MIN = 32'd1,
   parameter int          N_STEPS      = 8,
   parameter logic [4:0]  SPEED_MIN    = 5'd0,
   parameter logic [4:0]  SPEED_MAX    = 5'd7,
   parameter bit          SWEEP_CMD18  = 1'b1,
   parameter int          RST_CYCLES   = 16,
   parameter logic [31:0] TIMEOUT      = 32'hFFFF_FFFE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        uut_ctrl_mux,
   output logic        uut_rst,
   output logic        uut_start,
   output logic [31:0] uut_n_blocks,
   output logic [4:0]  uut_sclk_speed,
   output logic        uut_cmd18,
   input  logic        uut_finish,
   output logic        rec_valid,
   output logic [7:0]  rec_data,
   output logic        rec_last,
   input  logic        rec_ready,
   output logic [31:0] debug
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_SETUP  = 4'd1,
      S_LAUNCH = 4'd2,
      S_RUN    = 4'd3,
      S_EMIT   = 4'd4,
      S_NEXT   = 4'd5,
      S_DONE   = 4'd6
   } state_t;

   localparam logic [4:0]  LAST_STEP = 5'(N_STEPS - 1);
   localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [15:0] rst_cnt_reg;
   logic [31:0] cycle_cnt_reg;
   logic        timeout_flag_reg;
   logic [7:0]  seq_reg;
   logic [4:0]  step_reg;
   logic [4:0]  speed_reg;
   logic        cmd18_reg;
   logic [31:0] n_blocks_reg;
   logic [2:0]  byte_idx_reg;
   logic        rec_valid_reg, rec_last_reg;
   logic [7:0]  rec_data_reg;
   logic        busy_reg, done_reg, mux_reg, uut_rst_reg, uut_start_reg;

   logic        setup_end, byte_xfer, cmd18_wrap, speed_wrap, step_wrap, sweep_end;
   logic [2:0]  sel;
   logic [7:0]  byte_sel;

   assign setup_end  = (rst_cnt_reg == RST_LAST);
   assign byte_xfer  = rec_valid_reg && rec_ready;
   assign cmd18_wrap = !SWEEP_CMD18 || cmd18_reg;
   assign speed_wrap = (speed_reg == SPEED_MAX);
   assign step_wrap  = (step_reg == LAST_STEP);
   assign sweep_end  = cmd18_wrap && speed_wrap && step_wrap;

   always_ff @(posedge clk) begin
      if (!rst) state_reg <= S_IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (start) state_next = S_SETUP;
         S_SETUP:  if (setup_end) state_next = S_LAUNCH;
         S_LAUNCH: state_next = S_RUN;
         S_RUN:    if (uut_finish || cycle_cnt_reg == TIMEOUT) state_next = S_EMIT;
         S_EMIT:   if (byte_xfer && byte_idx_reg == 3'd7) state_next = S_NEXT;
         S_NEXT:   state_next = sweep_end ? S_DONE : S_SETUP;
         S_DONE:   if (!start) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
      if (abort) state_next = S_IDLE;
   end

   // Record byte to present next: byte 0 when a record opens, otherwise the successor.
   always_comb begin
      sel = (state_reg == S_EMIT) ? byte_idx_reg + 3'd1 : 3'd0;
      byte_sel = 8'h00;
      case (sel)
         3'd0:    byte_sel = {cmd18_reg, 2'b00, speed_reg};
         3'd1:    byte_sel = {3'b000, step_reg};
         3'd2:    byte_sel = cycle_cnt_reg[31:24];
         3'd3:    byte_sel = cycle_cnt_reg[23:16];
         3'd4:    byte_sel = cycle_cnt_reg[15:8];
         3'd5:    byte_sel = cycle_cnt_reg[7:0];
         3'd6:    byte_sel = {timeout_flag_reg, 7'b0000000};
         default: byte_sel = seq_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rst_cnt_reg      <= '0;
         cycle_cnt_reg    <= '0;
         timeout_flag_reg <= 1'b0;
         seq_reg          <= '0;
         step_reg         <= '0;
         speed_reg        <= SPEED_MIN;
         cmd18_reg        <= 1'b0;
         n_blocks_reg     <= N_BLOCKS_MIN;
         byte_idx_reg     <= '0;
         rec_valid_reg    <= 1'b0;
         rec_last_reg     <= 1'b0;
         rec_data_reg     <= '0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         mux_reg          <= 1'b0;
         uut_rst_reg      <= 1'b1;
         uut_start_reg    <= 1'b0;
      end else begin
         // Control outputs are registered decodes of the state being entered.
         busy_reg      <= (state_next != S_IDLE) && (state_next != S_DONE);
         mux_reg       <= (state_next != S_IDLE) && (state_next != S_DONE);
         done_reg      <= (state_next == S_DONE);
         uut_rst_reg   <= (state_next == S_IDLE) || (state_next == S_SETUP) ||
                          (state_next == S_DONE);
         uut_start_reg <= (state_next == S_LAUNCH);
         rst_cnt_reg   <= (state_reg == S_SETUP) ? rst_cnt_reg + 16'd1 : 16'd0;

         if (abort) begin
            rec_valid_reg <= 1'b0;
            rec_last_reg  <= 1'b0;
         end else begin
            case (state_reg)
               S_IDLE: begin
                  seq_reg          <= '0;
                  timeout_flag_reg <= 1'b0;
                  cycle_cnt_reg    <= '0;
                  if (start) begin
                     step_reg     <= '0;
                     speed_reg    <= SPEED_MIN;
                     cmd18_reg    <= 1'b0;
                     n_blocks_reg <= N_BLOCKS_MIN;
                  end
               end
               S_LAUNCH: cycle_cnt_reg <= 32'd1;
               S_RUN: begin
                  if (!uut_finish) begin
                     if (cycle_cnt_reg == TIMEOUT) timeout_flag_reg <= 1'b1;
                     else                          cycle_cnt_reg    <= cycle_cnt_reg + 32'd1;
                  end
                  if (state_next == S_EMIT) begin
                     rec_valid_reg <= 1'b1;
                     rec_data_reg  <= byte_sel;
                     rec_last_reg  <= 1'b0;
                     byte_idx_reg  <= '0;
                  end
               end
               S_EMIT: begin
                  if (byte_xfer) begin
                     if (byte_idx_reg == 3'd7) begin
                        rec_valid_reg <= 1'b0;
                        rec_last_reg  <= 1'b0;
                     end else begin
                        byte_idx_reg <= byte_idx_reg + 3'd1;
                        rec_data_reg <= byte_sel;
                        rec_last_reg <= (byte_idx_reg == 3'd6);
                     end
                  end
               end
               S_NEXT: begin
                  seq_reg          <= seq_reg + 8'd1;
                  timeout_flag_reg <= 1'b0;
                  // cmd18 is the innermost loop, then speed, then block-count step.
                  if (!sweep_end) begin
                     if (!cmd18_wrap) begin
                        cmd18_reg <= 1'b1;
                     end else begin
                        cmd18_reg <= 1'b0;
                        if (!speed_wrap) begin
                           speed_reg <= speed_reg + 5'd1;
                        end else begin
                           speed_reg    <= SPEED_MIN;
                           step_reg     <= step_reg + 5'd1;
                           n_blocks_reg <= N_BLOCKS_MIN << (step_reg + 5'd1);
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign busy           = busy_reg;
   assign done           = done_reg;
   assign uut_ctrl_mux   = mux_reg;
   assign uut_rst        = uut_rst_reg;
   assign uut_start      = uut_start_reg;
   assign uut_n_blocks   = n_blocks_reg;
   assign uut_sclk_speed = speed_reg;
   assign uut_cmd18      = cmd18_reg;
   assign rec_valid      = rec_valid_reg;
   assign rec_data       = rec_data_reg;
   assign rec_last       = rec_last_reg;
   assign debug          = {state_reg, timeout_flag_reg, 3'b000, seq_reg, cycle_cnt_reg[15:0]};

endmodule

// File: tb/tb_autotest_sweep_ctrl.sv
// Bench for autotest_sweep_ctrl: a small directed instance driven from a vector table
// plus abort/reset sequences, and a full 64-run instance with random UUT timing and backpressure.
module tb_autotest_sweep_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- instance A: 2-run sweep, TIMEOUT = 20 ----------------
   logic        a_rst = 1'b0, a_start = 1'b0, a_abort = 1'b0, a_finish = 1'b0, a_ready = 1'b1;
   logic        a_busy, a_done, a_mux, a_uut_rst, a_uut_start, a_cmd18, a_valid, a_last;
   logic [31:0] a_n_blocks, a_debug;
   logic [4:0]  a_speed;
   logic [7:0]  a_data;

   autotest_sweep_ctrl #(
      .N_BLOCKS_MIN(32'd1), .N_STEPS(1), .SPEED_MIN(5'd3), .SPEED_MAX(5'd3),
      .SWEEP_CMD18(1'b1), .RST_CYCLES(4), .TIMEOUT(32'd20)
   ) dut_a (
      .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort),
      .busy(a_busy), .done(a_done), .uut_ctrl_mux(a_mux), .uut_rst(a_uut_rst),
      .uut_start(a_uut_start), .uut_n_blocks(a_n_blocks), .uut_sclk_speed(a_speed),
      .uut_cmd18(a_cmd18), .uut_finish(a_finish), .rec_valid(a_valid), .rec_data(a_data),
      .rec_last(a_last), .rec_ready(a_ready), .debug(a_debug)
   );

   // ---------------- instance B: 4 steps x 8 speeds x 2 modes ----------------
   logic        b_rst = 1'b0, b_start = 1'b0, b_abort = 1'b0, b_finish = 1'b0, b_ready = 1'b1;
   logic        b_busy, b_done, b_mux, b_uut_rst, b_uut_start, b_cmd18, b_valid, b_last;
   logic [31:0] b_n_blocks, b_debug;
   logic [4:0]  b_speed;
   logic [7:0]  b_data;

   autotest_sweep_ctrl #(
      .N_BLOCKS_MIN(32'd3), .N_STEPS(4), .RST_CYCLES(2), .TIMEOUT(32'd40)
   ) dut_b (
      .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
      .busy(b_busy), .done(b_done), .uut_ctrl_mux(b_mux), .uut_rst(b_uut_rst),
      .uut_start(b_uut_start), .uut_n_blocks(b_n_blocks), .uut_sclk_speed(b_speed),
      .uut_cmd18(b_cmd18), .uut_finish(b_finish), .rec_valid(b_valid), .rec_data(b_data),
      .rec_last(b_last), .rec_ready(b_ready), .debug(b_debug)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- A: UUT model, ready driver, record monitor ----------------
   int         a_delay = 10;   // 0 = finish held high permanently
   int         a_cnt   = 0;
   bit         a_armed = 1'b0;
   bit         a_tog   = 1'b0;
   logic [7:0] a_q[$];
   bit         a_stall = 1'b0;
   logic [7:0] a_pdata;
   logic       a_plast;

   initial forever begin
      @(negedge clk);
      if (a_uut_rst) begin
         a_armed = 1'b0;
         a_cnt   = 0;
      end else if (a_uut_start) begin
         a_armed = 1'b1;
         a_cnt   = 0;
      end else if (a_armed) begin
         a_cnt++;
      end
      a_finish = (a_delay == 0) || (a_armed && a_cnt >= a_delay);
   end

   initial forever begin
      @(posedge clk);
      #1;
      a_ready = a_tog ? ~a_ready : 1'b1;
   end

   initial forever begin
      @(negedge clk);
      if (a_rst && !a_abort) begin
         if (a_stall) begin
            chk("a_hold_valid", a_valid, 1'b1);
            chk("a_hold_data", a_data, a_pdata);
            chk("a_hold_last", a_last, a_plast);
         end
         if (a_valid && a_ready) begin
            chk("a_last_pos", a_last, (a_q.size() % 8) == 7);
            a_q.push_back(a_data);
         end
         a_stall = a_valid && !a_ready;
         a_pdata = a_data;
         a_plast = a_last;
      end else begin
         a_stall = 1'b0;
      end
   end

   // ---------------- B: UUT model + scoreboard ----------------
   int         b_cfg_step[$], b_cfg_speed[$], b_cfg_c[$];
   int         b_delays[$];
   int         b_delay = 1;
   int         b_cnt   = 0;
   bit         b_armed = 1'b0;
   int         b_recs  = 0;
   int         b_starts = 0;
   logic [7:0] b_cur[$];
   bit         b_stall = 1'b0;
   logic [7:0] b_pdata;
   logic       b_plast;

   initial forever begin
      @(posedge clk);
      #1;
      b_ready = ($urandom_range(0, 3) != 0);
   end

   initial forever begin
      logic [63:0] act, exp;
      int          r, d, cnt;
      bit          to;
      @(negedge clk);
      if (b_uut_rst) begin
         b_armed = 1'b0;
         b_cnt   = 0;
      end else if (b_uut_start) begin
         b_armed = 1'b1;
         b_cnt   = 0;
         b_delay = $urandom_range(1, 50);
         b_delays.push_back(b_delay);
      end else if (b_armed) begin
         b_cnt++;
      end
      b_finish = b_armed && (b_cnt >= b_delay);

      if (b_rst) begin
         if (b_uut_start) begin
            if (b_starts < b_cfg_step.size()) begin
               chk("b_n_blocks", b_n_blocks, 32'd3 << b_cfg_step[b_starts]);
               chk("b_speed", b_speed, 5'(b_cfg_speed[b_starts]));
               chk("b_cmd18", b_cmd18, b_cfg_c[b_starts] != 0);
            end
            b_starts++;
         end
         if (b_stall) begin
            chk("b_hold_valid", b_valid, 1'b1);
            chk("b_hold_data", b_data, b_pdata);
            chk("b_hold_last", b_last, b_plast);
         end
         if (b_valid && b_ready) begin
            chk("b_last_pos", b_last, b_cur.size() == 7);
            b_cur.push_back(b_data);
         end
         b_stall = b_valid && !b_ready;
         b_pdata = b_data;
         b_plast = b_last;
         if (b_cur.size() == 8) begin
            act = '0;
            for (int i = 0; i < 8; i++) act = {act[55:0], b_cur[i]};
            r = b_recs;
            if (r < b_cfg_step.size() && r < b_delays.size()) begin
               d   = b_delays[r];
               to  = (d > 40);
               cnt = to ? 40 : d;
               exp = {(b_cfg_c[r] != 0), 2'b00, 5'(b_cfg_speed[r]), 3'b000, 5'(b_cfg_step[r]),
                      32'(cnt), to, 7'b0000000, 8'(r)};
               chk($sformatf("b_record_%0d", r), act, exp);
            end else begin
               chk("b_record_excess", r, b_cfg_step.size());
            end
            $display("b record %0d: %h", r, act);
            b_recs++;
            b_cur.delete();
         end
      end
   end

   // ---------------- A: directed vectors ----------------
   typedef struct {
      int          d0;
      int          d1;
      bit          tog;
      logic [63:0] r0;
      logic [63:0] r1;
   } vec_t;
   vec_t tbl[4];

   task automatic wait_a_bytes(input int n);
      int k = 0;
      while (a_q.size() < n && k < 2000) begin
         tick(1);
         k++;
      end
      chk("a_bytes_wait", a_q.size() >= n, 1'b1);
   endtask

   task automatic pop_rec(output logic [63:0] r);
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (a_q.size() > 0) r = {r[55:0], a_q.pop_front()};
         else                r = {r[55:0], 8'hxx};
      end
   endtask

   task automatic run_a_sweep(input int e);
      int          n;
      logic [63:0] r;
      a_delay = tbl[e].d0;
      a_tog   = tbl[e].tog;
      a_start = 1'b1;
      tick(1);
      chk("a_setup_busy", a_busy, 1'b1);
      chk("a_setup_uut_rst", a_uut_rst, 1'b1);
      chk("a_setup_mux", a_mux, 1'b1);
      n = 0;
      while (!a_uut_start && n < 100) begin
         tick(1);
         n++;
      end
      chk("a_setup_len", n, 4);
      chk("a_launch_uut_rst", a_uut_rst, 1'b0);
      wait_a_bytes(8);
      a_delay = tbl[e].d1;
      wait_a_bytes(16);
      n = 0;
      while (!a_done && n < 200) begin
         tick(1);
         n++;
      end
      chk("a_done", a_done, 1'b1);
      chk("a_done_mux", a_mux, 1'b0);
      chk("a_done_busy", a_busy, 1'b0);
      pop_rec(r);
      $display("a vector %0d record 0: %h", e, r);
      chk($sformatf("a_rec0_v%0d", e), r, tbl[e].r0);
      pop_rec(r);
      $display("a vector %0d record 1: %h", e, r);
      chk($sformatf("a_rec1_v%0d", e), r, tbl[e].r1);
      a_start = 1'b0;
      a_tog   = 1'b0;
      tick(1);
      chk("a_idle_after_done", a_done, 1'b0);
   endtask

   initial begin
      int n;
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl[0] = '{10,   10,   1'b0, 64'h0300_0000_000A_0000, 64'h8300_0000_000A_0001};
      tbl[1] = '{1000, 1000, 1'b0, 64'h0300_0000_0014_8000, 64'h8300_0000_0014_8001};
      tbl[2] = '{0,    20,   1'b1, 64'h0300_0000_0001_0000, 64'h8300_0000_0014_0001};
      tbl[3] = '{19,   1,    1'b1, 64'h0300_0000_0013_0000, 64'h8300_0000_0001_0001};

      tick(3);
      chk("a_rst_busy", a_busy, 1'b0);
      chk("a_rst_uut_rst", a_uut_rst, 1'b1);
      chk("a_rst_n_blocks", a_n_blocks, 32'd1);
      chk("a_rst_speed", a_speed, 5'd3);
      chk("a_rst_debug", a_debug, 32'd0);
      chk("b_rst_n_blocks", b_n_blocks, 32'd3);
      chk("b_rst_speed", b_speed, 5'd0);
      a_rst = 1'b1;
      b_rst = 1'b1;
      tick(2);

      for (int e = 0; e < 4; e++) run_a_sweep(e);

      // abort while the UUT is running
      a_delay = 1000;
      a_start = 1'b1;
      n = 0;
      while (!a_uut_start && n < 100) begin
         tick(1);
         n++;
      end
      tick(3);
      a_abort = 1'b1;
      a_start = 1'b0;
      tick(1);
      a_abort = 1'b0;
      chk("a_abort_run_busy", a_busy, 1'b0);
      chk("a_abort_run_mux", a_mux, 1'b0);
      chk("a_abort_run_valid", a_valid, 1'b0);
      tick(2);
      chk("a_abort_run_stay_idle", a_busy, 1'b0);

      // abort after byte 3 of a record
      a_delay = 5;
      a_start = 1'b1;
      wait_a_bytes(4);
      a_abort = 1'b1;
      a_start = 1'b0;
      tick(1);
      a_abort = 1'b0;
      chk("a_abort_emit_valid", a_valid, 1'b0);
      chk("a_abort_emit_last", a_last, 1'b0);
      chk("a_abort_emit_mux", a_mux, 1'b0);
      chk("a_abort_emit_busy", a_busy, 1'b0);
      tick(2);
      chk("a_abort_emit_bytes", a_q.size(), 4);
      a_q.delete();

      // a fresh start begins again at step 0, seq 0
      run_a_sweep(0);

      // reset asserted during SETUP
      a_start = 1'b1;
      tick(2);
      chk("a_in_setup", a_busy, 1'b1);
      a_rst   = 1'b0;
      a_start = 1'b0;
      tick(1);
      chk("a_srst_busy", a_busy, 1'b0);
      chk("a_srst_done", a_done, 1'b0);
      chk("a_srst_mux", a_mux, 1'b0);
      chk("a_srst_uut_start", a_uut_start, 1'b0);
      chk("a_srst_uut_rst", a_uut_rst, 1'b1);
      chk("a_srst_valid", a_valid, 1'b0);
      chk("a_srst_last", a_last, 1'b0);
      chk("a_srst_data", a_data, 8'h00);
      chk("a_srst_n_blocks", a_n_blocks, 32'd1);
      chk("a_srst_speed", a_speed, 5'd3);
      chk("a_srst_cmd18", a_cmd18, 1'b0);
      chk("a_srst_debug", a_debug, 32'd0);
      a_rst = 1'b1;
      tick(2);
      chk("a_srst_stays_idle", a_busy, 1'b0);

      // full randomized sweep on instance B
      for (int st = 0; st < 4; st++)
         for (int sp = 0; sp < 8; sp++)
            for (int c = 0; c < 2; c++) begin
               b_cfg_step.push_back(st);
               b_cfg_speed.push_back(sp);
               b_cfg_c.push_back(c);
            end
      b_start = 1'b1;
      n = 0;
      while (!b_done && n < 20000) begin
         tick(1);
         n++;
      end
      chk("b_done", b_done, 1'b1);
      chk("b_done_mux", b_mux, 1'b0);
      chk("b_records", b_recs, 64);
      chk("b_starts", b_starts, 64);
      b_start = 1'b0;
      tick(2);
      chk("b_idle", b_done, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
